// File: rtl/four_req_priority_arbiter.sv
// rtl/four_req_priority_arbiter.sv - four-requester arbiter with bounded tenure and timeout masking
//
// Grants one shared resource to one of four requesters. The default build uses
// fixed priority (req[3] highest). Defining ARB_ROUND_ROBIN_EN switches the
// selection to a rotating search that starts at rr_ptr.
//
// Ports:
//   clk       - single clock, all state updates on the rising edge
//   rst_n     - synchronous active-low reset
//   req[3:0]  - request vector, req[i] high = requester i wants the resource
//   grant     - registered one-hot grant, at most one bit high
//   grant_id  - registered index of the current or last winner
//   busy      - high while in GRANT or RECOVER
//   timeout   - one-cycle pulse when a grant is forcibly revoked
module four_req_priority_arbiter #(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic       timeout
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RECOVER = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic [3:0]       mask;
  logic [3:0]       eff;
  logic [1:0]       win;

`ifdef ARB_ROUND_ROBIN_EN
  logic [1:0]       rr_ptr;
  logic [1:0]       idx;
  logic             found;
`endif

  // A timed-out requester is hidden from exactly one IDLE arbitration.
  assign eff = req & ~mask;

  always_comb begin
    win = 2'd0;
`ifdef ARB_ROUND_ROBIN_EN
    found = 1'b0;
    idx   = rr_ptr;
    // Search upward from rr_ptr with wrap; the first set bit wins.
    for (int k = 0; k < 4; k++) begin
      idx = rr_ptr + 2'(k);
      if (!found && eff[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
`else
    if (eff[3])      win = 2'd3;
    else if (eff[2]) win = 2'd2;
    else if (eff[1]) win = 2'd1;
    else             win = 2'd0;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= 4'b0000;
      grant_id <= 2'b00;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      mask     <= 4'b0000;
`ifdef ARB_ROUND_ROBIN_EN
      rr_ptr   <= 2'b00;
`endif
    end else begin
      timeout <= 1'b0;
      unique case (state)
        IDLE: begin
          // The mask has done its job after a single arbitration either way.
          mask <= 4'b0000;
          if (eff != 4'b0000) begin
            grant    <= 4'b0001 << win;
            grant_id <= win;
            hold_cnt <= CNT_W'(1);
            busy     <= 1'b1;
            state    <= GRANT;
`ifdef ARB_ROUND_ROBIN_EN
            rr_ptr   <= win + 2'd1;
`endif
          end
        end
        GRANT: begin
          // Release is checked first so a drop on the final tenure cycle
          // is a clean release with no timeout and no mask.
          if (!req[grant_id]) begin
            grant <= 4'b0000;
            state <= RECOVER;
          end else if (hold_cnt == CNT_W'(MAX_HOLD)) begin
            grant   <= 4'b0000;
            timeout <= 1'b1;
            mask    <= 4'b0001 << grant_id;
            state   <= RECOVER;
          end else begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        RECOVER: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          grant <= 4'b0000;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_four_req_priority_arbiter.sv
// tb/tb_four_req_priority_arbiter.sv - randomized and directed self-checking bench for four_req_priority_arbiter
module tb_four_req_priority_arbiter;

  localparam int MAX_HOLD = 8;
  localparam int CNT_W    = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;

  int pass_cnt  = 0;
  int total_cnt = 0;

  four_req_priority_arbiter #(.MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .grant    (grant),
    .grant_id (grant_id),
    .busy     (busy),
    .timeout  (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: who owns the resource, for how long, whether the
  // one-cycle cooldown is pending, and who is barred from the next pick.
  int m_owner;
  int m_tenure;
  bit m_cool;
  int m_barred;
  int m_last;
  bit m_to;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_edge(input logic [3:0] r, input logic rn);
    if (!rn) begin
      m_owner = -1; m_cool = 0; m_barred = -1; m_last = 0; m_to = 0;
      return;
    end
    m_to = 0;
    if (m_owner >= 0) begin
      if (!r[m_owner]) begin
        m_owner = -1; m_cool = 1;
      end else if (m_tenure == MAX_HOLD) begin
        m_barred = m_owner; m_owner = -1; m_cool = 1; m_to = 1;
      end else begin
        m_tenure++;
      end
    end else if (m_cool) begin
      m_cool = 0;
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (m_owner < 0 && r[i] && i != m_barred) begin
          m_owner = i; m_tenure = 1; m_last = i;
        end
      end
      m_barred = -1;
    end
  endtask

  task automatic step(input logic [3:0] r, input logic rn);
    logic [3:0] eg;
    @(negedge clk);
    req   = r;
    rst_n = rn;
    @(posedge clk);
    model_edge(r, rn);
    #1;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    check("grant",    8'(grant),    8'(eg));
    check("grant_id", 8'(grant_id), 8'(m_last));
    check("busy",     8'(busy),     8'((m_owner >= 0) || m_cool));
    check("timeout",  8'(timeout),  8'(m_to));
  endtask

  int hi;
  int lo;

  initial begin
    req = 4'b0000;
    rst_n = 1'b0;
    m_owner = -1; m_tenure = 0; m_cool = 0; m_barred = -1; m_last = 0; m_to = 0;

    // Reset with all requests high, then priority on release.
    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    check("rst_grant", 8'(grant), 8'h00);
    check("rst_busy", 8'(busy), 8'h00);
    check("rst_timeout", 8'(timeout), 8'h00);
    step(4'b1111, 1'b1);
    check("prio_grant", 8'(grant), 8'h08);
    check("prio_id", 8'(grant_id), 8'h03);

    // Release path.
    step(4'b0000, 1'b0);
    step(4'b0110, 1'b1);
    check("rel_first", 8'(grant), 8'h04);
    step(4'b0110, 1'b1);
    step(4'b0110, 1'b1);
    step(4'b0010, 1'b1);
    check("rel_recover_grant", 8'(grant), 8'h00);
    check("rel_recover_busy", 8'(busy), 8'h01);
    step(4'b0010, 1'b1);
    check("rel_idle_busy", 8'(busy), 8'h00);
    check("rel_idle_id", 8'(grant_id), 8'h02);
    step(4'b0010, 1'b1);
    check("rel_next_grant", 8'(grant), 8'h02);
    check("rel_next_id", 8'(grant_id), 8'h01);

    // Timeout and mask with two contenders.
    step(4'b0000, 1'b0);
    hi = 0;
    repeat (MAX_HOLD) begin
      step(4'b1001, 1'b1);
      if (grant == 4'b1000) hi++;
    end
    check("to_tenure", 8'(hi), 8'(MAX_HOLD));
    step(4'b1001, 1'b1);
    check("to_pulse", 8'(timeout), 8'h01);
    check("to_grant_low", 8'(grant), 8'h00);
    step(4'b1001, 1'b1);
    check("to_pulse_end", 8'(timeout), 8'h00);
    step(4'b1001, 1'b1);
    check("mask_winner", 8'(grant), 8'h01);
    step(4'b1000, 1'b1);
    step(4'b1000, 1'b1);
    step(4'b1000, 1'b1);
    check("after_mask", 8'(grant), 8'h08);

    // Sole hog: re-granted after three low cycles.
    step(4'b0000, 1'b0);
    repeat (MAX_HOLD) step(4'b0100, 1'b1);
    lo = 0;
    step(4'b0100, 1'b1);
    check("hog_pulse", 8'(timeout), 8'h01);
    while (grant == 4'b0000 && lo < 10) begin
      lo++;
      step(4'b0100, 1'b1);
    end
    check("hog_gap", 8'(lo), 8'h03);
    check("hog_regrant", 8'(grant), 8'h04);

    // Release on the final tenure cycle: no timeout, no mask.
    step(4'b0000, 1'b0);
    repeat (MAX_HOLD) step(4'b1000, 1'b1);
    step(4'b0000, 1'b1);
    check("sim_timeout", 8'(timeout), 8'h00);
    check("sim_grant", 8'(grant), 8'h00);
    step(4'b1001, 1'b1);
    step(4'b1001, 1'b1);
    check("sim_nomask", 8'(grant), 8'h08);

    // Randomized traffic with occasional resets.
    repeat (2000) begin
      step(4'($urandom_range(0, 15)), ($urandom_range(0, 49) != 0));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
